// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmitter arbiter.
package uart_arb_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] TAG_BASE_DEF = 8'h80;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        GUARD     = 3'd3,
        WAIT_DONE = 3'd4,
        TAG       = 3'd5
    } state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             found,
    output logic [IDX_W-1:0] pick_idx
);
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        pick_idx = '0;
        // Scan farthest-first so the candidate nearest rr_ptr overwrites the others.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req_valid[IDX_W'(idx)]) begin
                found    = 1'b1;
                pick_idx = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter feeding one UART transmitter, one byte in flight.
// Optional UART_ARB_TAG_EN: prefix each granted packet with byte TAG_BASE | grant_idx.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int                N_REQ    = 2,
    parameter int                IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter logic [BYTE_W-1:0] TAG_BASE = TAG_BASE_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][BYTE_W-1:0]  req_data,
    input  logic [N_REQ-1:0]              req_last,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          tx_start,
    output logic [BYTE_W-1:0]             tx_data,
    input  logic                          tx_busy,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          grant_active
);
    state_e              state_q, state_d;
    logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
    logic                grant_active_q, grant_active_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                last_q, last_d;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .found     (pick_found),
        .pick_idx  (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            grant_idx_q    <= '0;
            grant_active_q <= 1'b0;
            rr_ptr_q       <= '0;
            tx_data_q      <= '0;
            last_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_idx_q    <= grant_idx_d;
            grant_active_q <= grant_active_d;
            rr_ptr_q       <= rr_ptr_d;
            tx_data_q      <= tx_data_d;
            last_q         <= last_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_idx_d    = grant_idx_q;
        grant_active_d = grant_active_q;
        rr_ptr_d       = rr_ptr_q;
        tx_data_d      = tx_data_q;
        last_d         = last_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_idx_d    = pick_idx;
                    grant_active_d = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_d        = TAG;
`else
                    state_d        = LOAD;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG: begin
                tx_data_d = TAG_BASE | BYTE_W'(grant_idx_q);
                last_d    = 1'b0;
                state_d   = START;
            end
`endif
            LOAD: begin
                // An idle owner keeps the lock; nobody else is considered here.
                if (req_valid[grant_idx_q]) begin
                    tx_data_d = req_data[grant_idx_q];
                    last_d    = req_last[grant_idx_q];
                    state_d   = START;
                end
            end
            START: state_d = GUARD;
            // tx_busy only rises the cycle after the start pulse, so skip one sample.
            GUARD: state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
                        state_d        = IDLE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == LOAD && req_valid[grant_idx_q]) begin
            req_ready[grant_idx_q] = 1'b1;
        end
        tx_start     = (state_q == START);
        tx_data      = tx_data_q;
        grant_idx    = grant_idx_q;
        grant_active = grant_active_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: stimulus queues expected frame bytes, a monitor pops them at each tx_start.
module tb_uart_tx_arbiter;
    localparam int FRAME = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0][7:0]  req_data;
    logic [1:0]       req_last;
    logic [1:0]       req_ready;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_busy;
    logic [0:0]       grant_idx;
    logic             grant_active;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;
    logic [7:0] exp_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] acc;
    logic       ss;
    int         busy_cnt;

    uart_tx_arbiter #(.N_REQ(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .grant_idx    (grant_idx),
        .grant_active (grant_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic exp_grant(input int i);
`ifdef UART_ARB_TAG_EN
        exp_q.push_back(8'h80 | 8'(i));
`else
        if (i < 0) exp_q.push_back(8'h00);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_tx_start"}, 32'(tx_start), 0);
        chk({nm, "_tx_data"}, 32'(tx_data), 0);
        chk({nm, "_grant_active"}, 32'(grant_active), 0);
        chk({nm, "_grant_idx"}, 32'(grant_idx), 0);
        chk({nm, "_req_ready"}, 32'(req_ready), 0);
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !grant_active && !tx_busy &&
                q0.size() == 0 && q1.size() == 0 && req_valid == 2'b00) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: pending %0d expected 0", nm, exp_q.size());
        end
    endtask

    task automatic wait_starts(input string nm, input int target);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 1000 && !ok; c++) begin
            @(negedge clk);
            if (start_cnt >= target) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: starts %0d expected %0d", nm, start_cnt, target);
        end
    endtask

    initial begin
        int s;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        tx_busy = 1'b0;
        busy_cnt = 0;
        acc = '0;
        ss = 1'b0;

        fork
            // Monitor: every start pulse must carry the next expected byte, transmitter idle.
            forever begin
                @(negedge clk);
                acc = req_valid & req_ready;
                if (!reset) begin
                    if (req_ready != 2'b00) chk("ready_onehot", 32'($onehot(req_ready)), 1);
                    if (tx_start) begin
                        start_cnt++;
                        chk("start_while_busy", 32'(tx_busy), 0);
                        if (exp_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_start: got %0h expected none", tx_data);
                        end else begin
                            chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
            // Transmitter model: busy from the cycle after start for FRAME cycles.
            forever begin
                @(negedge clk);
                ss = tx_start;
                @(posedge clk);
                #1;
                if (reset) busy_cnt = 0;
                else if (ss) busy_cnt = FRAME;
                else if (busy_cnt > 0) busy_cnt--;
                tx_busy = (busy_cnt != 0);
            end
            // Requester drivers: hold each byte until accepted, then present the next.
            forever begin
                logic [8:0] t;
                @(posedge clk);
                #1;
                if (acc[0]) req_valid[0] = 1'b0;
                if (acc[1]) req_valid[1] = 1'b0;
                if (!req_valid[0] && q0.size() > 0) begin
                    t = q0.pop_front();
                    req_data[0] = t[7:0]; req_last[0] = t[8]; req_valid[0] = 1'b1;
                end
                if (!req_valid[1] && q1.size() > 0) begin
                    t = q1.pop_front();
                    req_data[1] = t[7:0]; req_last[1] = t[8]; req_valid[1] = 1'b1;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Single 2-byte packet from req0.
        q0.push_back({1'b0, 8'h48}); q0.push_back({1'b1, 8'h49});
        exp_grant(0); exp_q.push_back(8'h48); exp_q.push_back(8'h49);
        wait_idle("t1");
        chk("t1_grant_released", 32'(grant_active), 0);

        // Both requesters valid at reset release.
        do_reset();
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
        exp_grant(0); exp_q.push_back(8'h10); exp_q.push_back(8'h11);
        exp_grant(1); exp_q.push_back(8'h20); exp_q.push_back(8'h21);
        @(negedge clk);
        reset = 1'b0;
        wait_idle("t2");
        // Pointer wrapped to 0: req0 wins a tie again.
        q0.push_back({1'b1, 8'h12}); q1.push_back({1'b1, 8'h22});
        exp_grant(0); exp_q.push_back(8'h12);
        exp_grant(1); exp_q.push_back(8'h22);
        wait_idle("t2b");

        // req1 arrives mid-way through req0's 3-byte packet.
        s = start_cnt;
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
        exp_grant(0); exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        exp_grant(1); exp_q.push_back(8'h61);
        wait_starts("t3", s + 1);
        q1.push_back({1'b1, 8'h61});
        wait_idle("t3");

        // Owner goes quiet mid-packet: lock holds, no starts, req1 waits.
        s = start_cnt;
        q0.push_back({1'b0, 8'h30});
        exp_grant(0); exp_q.push_back(8'h30);
        wait_starts("t4", s + exp_q.size());
        repeat (FRAME + 4) @(negedge clk);
        q1.push_back({1'b1, 8'h60});
        s = start_cnt;
        repeat (50) @(negedge clk);
        chk("t4_no_start", 32'(start_cnt - s), 0);
        chk("t4_lock_idx", 32'(grant_idx), 0);
        chk("t4_lock_active", 32'(grant_active), 1);
        q0.push_back({1'b1, 8'h31});
        exp_q.push_back(8'h31);
        exp_grant(1); exp_q.push_back(8'h60);
        wait_idle("t4");

        // Reset while the transmitter is mid-frame.
        s = start_cnt;
        q0.push_back({1'b0, 8'h50}); q0.push_back({1'b1, 8'h51});
        exp_grant(0); exp_q.push_back(8'h50);
        wait_starts("t5", s + exp_q.size());
        repeat (3) @(negedge clk);
        chk("t5_in_wait", 32'(tx_busy), 1);
        do_reset();
        chk_reset_outputs("t5");
        reset = 1'b0;
        q1.push_back({1'b1, 8'h55});
        exp_grant(1); exp_q.push_back(8'h55);
        wait_idle("t5b");

        // Single-byte packet from req1 alone (tagged when the option is built in).
        q1.push_back({1'b1, 8'h41});
        exp_grant(1); exp_q.push_back(8'h41);
        wait_idle("t6");
        chk("exp_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter of mother_board among N_REQ byte-stream requesters, e.g. CPU console port and debug/monitor port.
- Round-robin arbitration with packet lock: a granted requester keeps the transmitter until it sends a byte marked last.
- Sits between the requesters and the transmitter's start/data/busy interface; one byte in flight at a time.

Parameters:
N_REQ, 2, number of requesters (2..8)
IDX_W, $clog2(N_REQ) (min 1), width of grant index
TAG_BASE, 8'h80, tag byte base value (used only with optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  requester i has a byte on req_data[i]
req_data  in  N_REQ x 8  byte per requester
req_last  in  N_REQ  byte on req_data[i] ends requester i's packet
req_ready  out  N_REQ  one-hot; byte i accepted this cycle
tx_start  out  1  one-cycle pulse: transmitter latches tx_data
tx_data  out  8  byte to transmitter, held from start pulse until next accept
tx_busy  in  1  transmitter busy; rises the cycle after tx_start, falls when the stop bit ends
grant_idx  out  IDX_W  current owner (debug)
grant_active  out  1  a packet is locked to grant_idx

Behaviour:
- Reset values: all outputs 0; state=IDLE; rr_ptr=0; transmitter assumed idle.
- States: IDLE, LOAD, START, GUARD, WAIT_DONE (plus TAG with the option).
- IDLE: if any req_valid, pick first valid index searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - grant_idx <= pick; grant_active <= 1; go to LOAD.
- LOAD, with grant held: when req_valid[grant_idx]=1:
  - req_ready[grant_idx]=1 for exactly that cycle (combinational from state and valid).
  - Capture tx_data <= req_data[grant_idx] and last_q <= req_last[grant_idx]; go to START.
  - If the owner's valid is low, stay in LOAD indefinitely. The lock is not broken.
- START: tx_start=1 for one cycle; go to GUARD.
- GUARD: one cycle; tx_busy ignored (covers its 1-cycle rise latency); go to WAIT_DONE.
- WAIT_DONE: stay while tx_busy=1. On tx_busy=0:
  - If last_q=0, return to LOAD.
  - If last_q=1: grant_active <= 0; rr_ptr <= grant_idx+1 (wrap to 0 at N_REQ); go to IDLE.
- Latency: req accept to tx_start is 1 cycle. Byte-to-byte gap is 3 cycles of overhead plus the frame time.
- Requester handshake: byte transfers when req_valid and req_ready are both high. req_data/req_last must be stable while valid is high and not yet accepted.
- Simultaneous requests: round-robin order only; no requester is granted twice in a row while another is valid at IDLE.
- Single requester: rr_ptr wrap still selects it every packet with no idle cycles beyond the IDLE->LOAD cycle.
- Packet of one byte: req_last=1 on the first byte releases the grant after that frame.
- Reset mid-frame: FSM returns to IDLE immediately and the partially committed packet is abandoned. Reset is shared, so the transmitter is reset in the same cycle.
- Arbiter never asserts tx_start unless in START; never more than one req_ready bit high.

Optional Feature:
UART_ARB_TAG_EN
- Defined: on grant, before the first LOAD, state TAG sends byte TAG_BASE | grant_idx through START/GUARD/WAIT_DONE with last_q=0. The host can demultiplex streams. Example: requester 1 packet "A" gives frames 0x81, 0x41.
- Undefined: TAG state is absent; IDLE goes directly to LOAD; raw bytes only.

Decomposition:
- Package uart_arb_pkg:
  - state enum (IDLE, LOAD, START, GUARD, WAIT_DONE, TAG)
  - BYTE_W=8
  - TAG_BASE default constant
- Sub-module rr_pick (combinational): inputs req_valid and rr_ptr; outputs found and the chosen index. Instantiated once.

Test Plan:
- Req0 sends packet 0x48,0x49(last) while idle -> tx_start twice, tx_data 0x48 then 0x49, each start only after tx_busy falls; grant_active drops after the second frame.
- Req0 and req1 both valid at reset release, each with a 2-byte packet -> order 0,0,1,1; rr_ptr ends at 0.
- Req1 asserts valid mid-way through req0's 3-byte packet -> req0 bytes are contiguous; req1 is granted only after req0's last byte.
- Owner drops valid for 50 cycles mid-packet -> stays in LOAD, no tx_start, req1 not granted; resumes on valid.
- Reset pulsed during WAIT_DONE -> next cycle all outputs 0, state IDLE; a fresh request is served normally.
- With UART_ARB_TAG_EN, req1 sends 0x41(last) -> frames 0x81 then 0x41; without the macro -> only 0x41.
